// File: rtl/sw_mem_write_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// sw_mem_pkg : shared state encoding and default sizes for the switch write path
// Rev 1.0
// =============================================================================
package sw_mem_pkg;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_DEBOUNCE = 3;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sw_mem_write_ctrl_debounce.sv
`default_nettype none
// =============================================================================
// sw_debounce : 2-flop synchroniser, stability counter and rising-edge detect
// Rev 1.0
// =============================================================================
module sw_debounce
  import sw_mem_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign level = db_q;
  assign rise  = db_q & ~db_dly_q;

endmodule
`default_nettype wire

// File: rtl/sw_mem_write_ctrl.sv
`default_nettype none
// =============================================================================
// sw_mem_write_ctrl : post-reset clear sweep and one write per debounced press
// Rev 1.0
// =============================================================================
module sw_mem_write_ctrl
  import sw_mem_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DEBOUNCE  = DEF_DEBOUNCE,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              we_sw,
  input  logic [ADDR_W-1:0] addr_sw,
  input  logic [DATA_W-1:0] data_sw,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic [7:0]        wr_count,
  output logic [1:0]        st
);

  // Debounced level is only trustworthy once the sync/debounce pipe has refilled
  localparam int SETTLE = DEBOUNCE + 2;
  localparam int SET_W  = $clog2(SETTLE + 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]  cap_data_q, cap_data_d;
  logic [7:0]         wr_count_q, wr_count_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               arm_q, arm_d;
  logic               we_level, we_rise;

  sw_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk_2 (clk_2),
    .reset (reset),
    .raw   (we_sw),
    .level (we_level),
    .rise  (we_rise)
  );

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    wr_count_d = wr_count_q;
    settle_d   = settle_q;
    arm_d      = arm_q;

    if (settle_q != SET_W'(SETTLE)) begin
      settle_d = settle_q + SET_W'(1);
    end
    // A switch held since reset must be released before it can write
    if ((settle_q == SET_W'(SETTLE)) && !we_level) begin
      arm_d = 1'b1;
    end

    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (we_rise && arm_q) begin
          cap_addr_d = addr_sw;
          cap_data_d = data_sw;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_count_d = wr_count_q + 8'd1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (!we_level) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      wr_count_q <= '0;
      settle_q   <= '0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      wr_count_q <= wr_count_d;
      settle_q   <= settle_d;
      arm_q      <= arm_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cap_addr_q;
    mem_wdata = cap_data_q;
    busy      = 1'b1;
    st        = state_q;
    if (reset) begin
      mem_we    = 1'b1;
      mem_addr  = '0;
      mem_wdata = CLEAR_VAL;
      st        = ST_CLEAR;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_addr  = clr_ptr_q;
          mem_wdata = CLEAR_VAL;
        end
        ST_IDLE: begin
          busy      = 1'b0;
          mem_addr  = addr_sw;
          mem_wdata = data_sw;
        end
        ST_WRITE: mem_we = 1'b1;
        default:  mem_we = 1'b0;
      endcase
    end
  end

  assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_mem_write_ctrl.sv
`default_nettype none
// =============================================================================
// tb_sw_mem_write_ctrl : scoreboard bench for the switch-driven write controller
// Rev 1.0
// =============================================================================
module tb_sw_mem_write_ctrl;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 2;
  localparam int DEBOUNCE = 3;
  localparam int DEPTH    = 4;

  logic              clk_2 = 1'b0;
  logic              reset;
  logic              we_sw;
  logic [ADDR_W-1:0] addr_sw;
  logic [DATA_W-1:0] data_sw;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic [7:0]        wr_count;
  logic [1:0]        st;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_cnt;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  sw_mem_write_ctrl dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .we_sw     (we_sw),
    .addr_sw   (addr_sw),
    .data_sw   (data_sw),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .wr_count  (wr_count),
    .st        (st)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  // Every non-reset write cycle must match the oldest queued expectation
  always @(negedge clk_2) begin
    if (!reset && mem_we) begin
      check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr_sb", 32'(mem_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data_sb", 32'(mem_wdata), 32'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    check("rst_we", 32'(mem_we), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_st", 32'(st), 32'd0);
    check("rst_cnt", 32'(wr_count), 32'd0);
    exp_cnt = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({ADDR_W'(i), DATA_W'(0)});
    end
    reset = 1'b0;
    tick(DEPTH);
    check("clr_done_st", 32'(st), 32'd1);
    check("clr_done_busy", 32'(busy), 32'd0);
  endtask

  task automatic press(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int hold);
    addr_sw = a;
    data_sw = d;
    if (hold >= DEBOUNCE) begin
      exp_q.push_back({a, d});
      exp_cnt = exp_cnt + 8'd1;
    end
    we_sw = 1'b1;
    tick(hold);
    we_sw = 1'b0;
    tick(12);
    check("press_st", 32'(st), 32'd1);
    check("press_cnt", 32'(wr_count), 32'(exp_cnt));
  endtask

  initial begin
    reset   = 1'b1;
    we_sw   = 1'b0;
    addr_sw = '0;
    data_sw = '0;
    exp_cnt = 8'd0;

    do_reset(1);

    // Single long press, then switch changes while in HOLD
    addr_sw = 2'd2;
    data_sw = 4'd9;
    exp_q.push_back({2'd2, 4'd9});
    exp_cnt = exp_cnt + 8'd1;
    we_sw = 1'b1;
    tick(5);
    check("pre_we", 32'(mem_we), 32'd0);
    check("pre_st", 32'(st), 32'd1);
    tick(1);
    check("edge6_we", 32'(mem_we), 32'd1);
    check("edge6_addr", 32'(mem_addr), 32'd2);
    check("edge6_data", 32'(mem_wdata), 32'd9);
    tick(1);
    check("hold_st", 32'(st), 32'd3);
    check("hold_cnt", 32'(wr_count), 32'(exp_cnt));
    addr_sw = 2'd1;
    data_sw = 4'd5;
    tick(3);
    check("hold_addr", 32'(mem_addr), 32'd2);
    check("hold_data", 32'(mem_wdata), 32'd9);
    check("hold_busy", 32'(busy), 32'd1);
    we_sw = 1'b0;
    tick(4);
    check("rel_still_hold", 32'(st), 32'd3);
    tick(3);
    check("rel_idle_st", 32'(st), 32'd1);
    check("idle_rd_addr", 32'(mem_addr), 32'd1);
    check("idle_rd_data", 32'(mem_wdata), 32'd5);

    // Glitch filtering around the DEBOUNCE boundary
    press(2'd1, 4'd3, 1);
    press(2'd1, 4'd3, 2);
    press(2'd3, 4'd7, 3);

    // Counter wrap after 256 presses
    do_reset(2);
    for (int i = 0; i < 256; i++) begin
      press(ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom_range(0, 15)), 3 + $urandom_range(0, 2));
    end
    check("wrap_cnt", 32'(wr_count), 32'd0);

    // Reset in HOLD at wr_count=7 with the switch held through reset and CLEAR
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      press(ADDR_W'(i), DATA_W'(i + 8), 4);
    end
    addr_sw = 2'd3;
    data_sw = 4'd12;
    exp_q.push_back({2'd3, 4'd12});
    exp_cnt = exp_cnt + 8'd1;
    we_sw = 1'b1;
    tick(9);
    check("pre_rst_st", 32'(st), 32'd3);
    check("pre_rst_cnt", 32'(wr_count), 32'd7);
    do_reset(1);
    tick(20);
    check("held_idle_st", 32'(st), 32'd1);
    check("held_no_write", 32'(wr_count), 32'd0);
    we_sw = 1'b0;
    tick(10);
    press(2'd2, 4'd6, 4);
    check("fresh_press_cnt", 32'(wr_count), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
